csr_trap_seq: RTL and testbench

Trap entry/exit sequencer for the machine-mode CSR file. It accepts ecall, ebreak, mret and timer/external interrupt requests from the execute stage and stalls the pipeline. It then issues the required CSR writes (mepc, mcause, mstatus) one per cycle through the clint-side CSR write port, and finally pulses a PC redirect to the trap vector or to mepc.

---
 rtl/csr_trap_if.sv | 37 +++
 rtl/csr_trap_seq.sv | 154 +++++++++++++++
 tb/tb_csr_trap_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_if.sv
// Execute-stage request / CSR-file status / CSR write-port bundle for the trap sequencer.
// The master modport is the pipeline/CSR side; the slave modport is csr_trap_seq.
interface csr_trap_if;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        exu_csr_we_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_addr_o;
  logic        trap_active_o;

  modport master (
    output inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_timer_i, irq_ext_i,
           exu_csr_we_i, mtvec_i, mepc_i, mstatus_i, mie_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_addr_o,
           trap_active_o
  );

  modport slave (
    input  inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_timer_i, irq_ext_i,
           exu_csr_we_i, mtvec_i, mepc_i, mstatus_i, mie_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_addr_o,
           trap_active_o
  );
endinterface

// File: rtl/csr_trap_seq.sv
// Machine-mode trap entry/exit sequencer: stalls, writes mepc/mcause/mstatus, then redirects.
// Optional vectored interrupt dispatch is enabled by defining CSR_TRAP_VECTORED_EN.
module csr_trap_seq #(
  parameter bit EBREAK_TRAP = 1'b1,
  parameter bit IRQ_EXT_EN  = 1'b1
) (
  input logic        clk,
  input logic        rst,
  csr_trap_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, TRAP_JMP, R_MSTATUS, RET_JMP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] cause_reg, cause_next;

  logic        ext_req, tmr_req, ecall_req, ebreak_req, mret_req, trap_req;
  logic [31:0] trap_cause;
  logic        port_grant;
  logic [31:0] trap_base, trap_target;
  logic [31:0] mstatus_trap, mstatus_ret;

  logic        csr_we, stall, redirect, trap_active;
  logic [31:0] csr_waddr, csr_wdata, redirect_addr;

  assign ext_req    = bus.inst_valid_i & bus.mstatus_i[3] & bus.mie_i[11] & bus.irq_ext_i & IRQ_EXT_EN;
  assign tmr_req    = bus.inst_valid_i & bus.mstatus_i[3] & bus.mie_i[7] & bus.irq_timer_i;
  assign ecall_req  = bus.inst_valid_i & bus.ecall_i;
  assign ebreak_req = bus.inst_valid_i & bus.ebreak_i & EBREAK_TRAP;
  assign mret_req   = bus.inst_valid_i & bus.mret_i;
  assign trap_req   = ext_req | tmr_req | ecall_req | ebreak_req;

  assign trap_cause = ext_req   ? 32'h8000_000B :
                      tmr_req   ? 32'h8000_0007 :
                      ecall_req ? 32'h0000_000B : 32'h0000_0003;

  // The execute unit owns the CSR port whenever it writes; we retry next cycle.
  assign port_grant = ~bus.exu_csr_we_i;

  assign mstatus_trap = {bus.mstatus_i[31:8], bus.mstatus_i[3], bus.mstatus_i[6:4], 1'b0,
                         bus.mstatus_i[2:0]};
  assign mstatus_ret  = {bus.mstatus_i[31:8], 1'b1, bus.mstatus_i[6:4], bus.mstatus_i[7],
                         bus.mstatus_i[2:0]};

  assign trap_base = {bus.mtvec_i[31:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
  // Interrupts in vectored mode land at base + 4*cause code.
  assign trap_target = (bus.mtvec_i[1:0] == 2'b01 && cause_reg[31])
                     ? trap_base + {25'd0, cause_reg[4:0], 2'b00}
                     : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
  assign trap_target = trap_base;
`endif

  logic unused_mie;
  assign unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    cause_next    = cause_reg;
    csr_we        = 1'b0;
    csr_waddr     = '0;
    csr_wdata     = '0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    trap_active   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trap_req) begin
          stall      = 1'b1;
          pc_next    = bus.inst_addr_i;
          cause_next = trap_cause;
          state_next = W_MEPC;
        end else if (mret_req) begin
          stall      = 1'b1;
          pc_next    = bus.inst_addr_i;
          state_next = R_MSTATUS;
        end
      end
      W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS: begin
        stall       = 1'b1;
        trap_active = 1'b1;
        csr_we      = port_grant;
        case (state_reg)
          W_MEPC:    begin csr_waddr = 32'h341; csr_wdata = pc_reg;       end
          W_MCAUSE:  begin csr_waddr = 32'h342; csr_wdata = cause_reg;    end
          W_MSTATUS: begin csr_waddr = 32'h300; csr_wdata = mstatus_trap; end
          default:   begin csr_waddr = 32'h300; csr_wdata = mstatus_ret;  end
        endcase
        if (port_grant) begin
          case (state_reg)
            W_MEPC:    state_next = W_MCAUSE;
            W_MCAUSE:  state_next = W_MSTATUS;
            W_MSTATUS: state_next = TRAP_JMP;
            default:   state_next = RET_JMP;
          endcase
        end
      end
      TRAP_JMP: begin
        stall         = 1'b1;
        trap_active   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = trap_target;
        state_next    = IDLE;
      end
      RET_JMP: begin
        stall         = 1'b1;
        trap_active   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = bus.mepc_i;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset forces quiet outputs in the very cycle it is asserted, so no stray pulse escapes.
    if (rst) begin
      csr_we        = 1'b0;
      csr_waddr     = '0;
      csr_wdata     = '0;
      stall         = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      trap_active   = 1'b0;
    end
  end

  assign bus.csr_we_o        = csr_we;
  assign bus.csr_waddr_o     = csr_waddr;
  assign bus.csr_wdata_o     = csr_wdata;
  assign bus.stall_o         = stall;
  assign bus.redirect_o      = redirect;
  assign bus.redirect_addr_o = redirect_addr;
  assign bus.trap_active_o   = trap_active;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: directed literal scenarios plus randomized traffic
// checked every cycle against a step-list model of the trap/return sequences.
module tb_csr_trap_seq;
  localparam bit EBREAK_TRAP = 1'b1;
  localparam bit IRQ_EXT_EN  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_trap_if bus ();

  csr_trap_seq #(.EBREAK_TRAP(EBREAK_TRAP), .IRQ_EXT_EN(IRQ_EXT_EN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {S_EPC, S_CAUSE, S_MST_TRAP, S_MST_RET, S_JTRAP, S_JRET} step_e;
  step_e       steps[$];
  logic [31:0] m_pc, m_cause;

  function automatic logic [31:0] vec_target(logic [31:0] cause, logic [31:0] mtvec);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * cause[4:0];
`endif
    return base;
  endfunction

  always @(negedge clk) begin : model_cmp
    logic        e_we, e_st, e_rd, e_act, is_wr, trap, ret;
    logic [31:0] e_wa, e_wd, e_ra, cause, ms;
    e_we = 0; e_st = 0; e_rd = 0; e_act = 0; is_wr = 0; trap = 0; ret = 0;
    e_wa = 0; e_wd = 0; e_ra = 0; cause = 0;
    ms = bus.mstatus_i;
    if (rst) begin
      steps.delete();
    end else if (steps.size() == 0) begin
      if (bus.inst_valid_i) begin
        if (IRQ_EXT_EN && ms[3] && bus.mie_i[11] && bus.irq_ext_i) begin trap = 1; cause = 32'h8000000B; end
        else if (ms[3] && bus.mie_i[7] && bus.irq_timer_i)         begin trap = 1; cause = 32'h80000007; end
        else if (bus.ecall_i)                                       begin trap = 1; cause = 32'hB; end
        else if (EBREAK_TRAP && bus.ebreak_i)                       begin trap = 1; cause = 32'h3; end
        else if (bus.mret_i)                                        ret = 1;
      end
      if (trap) begin
        e_st = 1; m_pc = bus.inst_addr_i; m_cause = cause;
        steps.push_back(S_EPC); steps.push_back(S_CAUSE);
        steps.push_back(S_MST_TRAP); steps.push_back(S_JTRAP);
      end else if (ret) begin
        e_st = 1; m_pc = bus.inst_addr_i;
        steps.push_back(S_MST_RET); steps.push_back(S_JRET);
      end
    end else begin
      e_st = 1; e_act = 1;
      case (steps[0])
        S_EPC:      begin is_wr = 1; e_wa = 32'h341; e_wd = m_pc; end
        S_CAUSE:    begin is_wr = 1; e_wa = 32'h342; e_wd = m_cause; end
        S_MST_TRAP: begin is_wr = 1; e_wa = 32'h300; e_wd = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0); end
        S_MST_RET:  begin is_wr = 1; e_wa = 32'h300; e_wd = (ms & ~32'h08) | 32'h80 | (ms[7] ? 32'h8 : 32'h0); end
        S_JTRAP:    begin e_rd = 1; e_ra = vec_target(m_cause, bus.mtvec_i); end
        default:    begin e_rd = 1; e_ra = bus.mepc_i; end
      endcase
      if (is_wr) e_we = !bus.exu_csr_we_i;
      if (!is_wr || e_we) void'(steps.pop_front());
    end
    chk("m_csr_we", {31'd0, bus.csr_we_o}, {31'd0, e_we});
    chk("m_waddr", bus.csr_waddr_o, e_wa);
    chk("m_wdata", bus.csr_wdata_o, e_wd);
    chk("m_stall", {31'd0, bus.stall_o}, {31'd0, e_st});
    chk("m_redirect", {31'd0, bus.redirect_o}, {31'd0, e_rd});
    chk("m_raddr", bus.redirect_addr_o, e_ra);
    chk("m_active", {31'd0, bus.trap_active_o}, {31'd0, e_act});
  end

  // ---------------- directed helpers ----------------
  task automatic clear_req();
    bus.inst_valid_i = 0; bus.ecall_i = 0; bus.ebreak_i = 0; bus.mret_i = 0;
    bus.irq_timer_i = 0; bus.irq_ext_i = 0; bus.exu_csr_we_i = 0;
  endtask

  task automatic lit(string name, bit we, logic [31:0] wa, logic [31:0] wd, bit st, bit rd,
                     logic [31:0] ra, bit act);
    @(negedge clk);
    chk({name, "_we"}, {31'd0, bus.csr_we_o}, {31'd0, we});
    chk({name, "_waddr"}, bus.csr_waddr_o, wa);
    chk({name, "_wdata"}, bus.csr_wdata_o, wd);
    chk({name, "_stall"}, {31'd0, bus.stall_o}, {31'd0, st});
    chk({name, "_redir"}, {31'd0, bus.redirect_o}, {31'd0, rd});
    chk({name, "_raddr"}, bus.redirect_addr_o, ra);
    chk({name, "_active"}, {31'd0, bus.trap_active_o}, {31'd0, act});
    @(posedge clk); #1;
  endtask

  logic [31:0] vec_exp;

  initial begin
    clear_req();
    bus.inst_addr_i = 0; bus.mtvec_i = 0; bus.mepc_i = 0; bus.mstatus_i = 0; bus.mie_i = 0;
    rst = 1;
    @(posedge clk); #1;
    lit("rst0", 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    lit("idle0", 0, 0, 0, 0, 0, 0, 0);

    // ecall at 0x100 -> mtvec 0x200
    bus.mtvec_i = 32'h200; bus.mstatus_i = 32'h8;
    bus.inst_valid_i = 1; bus.ecall_i = 1; bus.inst_addr_i = 32'h100;
    lit("ecall_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("ecall_mepc", 1, 32'h341, 32'h100, 1, 0, 0, 1);
    lit("ecall_mcause", 1, 32'h342, 32'hB, 1, 0, 0, 1);
    lit("ecall_mstatus", 1, 32'h300, 32'h80, 1, 0, 0, 1);
    lit("ecall_jmp", 0, 0, 0, 1, 1, 32'h200, 1);
    lit("ecall_done", 0, 0, 0, 0, 0, 0, 0);

    // mret to mepc 0x104
    bus.mepc_i = 32'h104; bus.mstatus_i = 32'h80;
    bus.inst_valid_i = 1; bus.mret_i = 1; bus.inst_addr_i = 32'h50;
    lit("mret_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("mret_mstatus", 1, 32'h300, 32'h88, 1, 0, 0, 1);
    lit("mret_jmp", 0, 0, 0, 1, 1, 32'h104, 1);
    lit("mret_done", 0, 0, 0, 0, 0, 0, 0);

    // timer masked by MIE=0, then taken over a simultaneous ecall
    bus.mstatus_i = 32'h0; bus.mie_i = 32'h80;
    bus.inst_valid_i = 1; bus.irq_timer_i = 1; bus.inst_addr_i = 32'h300;
    lit("tmr_masked", 0, 0, 0, 0, 0, 0, 0);
    bus.mstatus_i = 32'h8; bus.ecall_i = 1;
    lit("tmr_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("tmr_mepc", 1, 32'h341, 32'h300, 1, 0, 0, 1);
    lit("tmr_mcause", 1, 32'h342, 32'h80000007, 1, 0, 0, 1);
    lit("tmr_mstatus", 1, 32'h300, 32'h80, 1, 0, 0, 1);
    lit("tmr_jmp", 0, 0, 0, 1, 1, 32'h200, 1);
    lit("tmr_done", 0, 0, 0, 0, 0, 0, 0);

    // execute unit holds the CSR port for two cycles during mcause
    bus.mie_i = 0; bus.inst_valid_i = 1; bus.ecall_i = 1; bus.inst_addr_i = 32'h400;
    lit("cont_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("cont_mepc", 1, 32'h341, 32'h400, 1, 0, 0, 1);
    bus.exu_csr_we_i = 1;
    lit("cont_hold1", 0, 32'h342, 32'hB, 1, 0, 0, 1);
    lit("cont_hold2", 0, 32'h342, 32'hB, 1, 0, 0, 1);
    bus.exu_csr_we_i = 0;
    lit("cont_mcause", 1, 32'h342, 32'hB, 1, 0, 0, 1);
    lit("cont_mstatus", 1, 32'h300, 32'h80, 1, 0, 0, 1);
    lit("cont_jmp", 0, 0, 0, 1, 1, 32'h200, 1);
    lit("cont_done", 0, 0, 0, 0, 0, 0, 0);

    // reset while writing mcause aborts the sequence
    bus.inst_valid_i = 1; bus.ecall_i = 1; bus.inst_addr_i = 32'h500;
    lit("rstmid_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("rstmid_mepc", 1, 32'h341, 32'h500, 1, 0, 0, 1);
    rst = 1;
    lit("rstmid_rst", 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    lit("rstmid_idle1", 0, 0, 0, 0, 0, 0, 0);
    lit("rstmid_idle2", 0, 0, 0, 0, 0, 0, 0);
    lit("rstmid_idle3", 0, 0, 0, 0, 0, 0, 0);

    // external interrupt with vectored-mode mtvec
`ifdef CSR_TRAP_VECTORED_EN
    vec_exp = 32'h22C;
`else
    vec_exp = 32'h200;
`endif
    bus.mtvec_i = 32'h201; bus.mie_i = 32'h800; bus.mstatus_i = 32'h8;
    bus.inst_valid_i = 1; bus.irq_ext_i = 1; bus.inst_addr_i = 32'h600;
    lit("ext_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("ext_mepc", 1, 32'h341, 32'h600, 1, 0, 0, 1);
    lit("ext_mcause", 1, 32'h342, 32'h8000000B, 1, 0, 0, 1);
    lit("ext_mstatus", 1, 32'h300, 32'h80, 1, 0, 0, 1);
    lit("ext_jmp", 0, 0, 0, 1, 1, vec_exp, 1);
    lit("ext_done", 0, 0, 0, 0, 0, 0, 0);

    // ebreak: an exception, so always the base even in vectored mode
    bus.mie_i = 0; bus.inst_valid_i = 1; bus.ebreak_i = 1; bus.inst_addr_i = 32'h700;
    lit("ebrk_T", 0, 0, 0, 1, 0, 0, 0);
    clear_req();
    lit("ebrk_mepc", 1, 32'h341, 32'h700, 1, 0, 0, 1);
    lit("ebrk_mcause", 1, 32'h342, 32'h3, 1, 0, 0, 1);
    lit("ebrk_mstatus", 1, 32'h300, 32'h80, 1, 0, 0, 1);
    lit("ebrk_jmp", 0, 0, 0, 1, 1, 32'h200, 1);
    lit("ebrk_done", 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.inst_valid_i = ($urandom_range(0, 9) < 6);
      bus.inst_addr_i  = $urandom & 32'hFFFF_FFFC;
      bus.ecall_i      = ($urandom_range(0, 3) == 0);
      bus.ebreak_i     = ($urandom_range(0, 3) == 0);
      bus.mret_i       = ($urandom_range(0, 3) == 0);
      bus.irq_timer_i  = ($urandom_range(0, 4) == 0);
      bus.irq_ext_i    = ($urandom_range(0, 4) == 0);
      bus.exu_csr_we_i = ($urandom_range(0, 9) < 3);
      bus.mtvec_i      = $urandom;
      bus.mepc_i       = $urandom;
      bus.mstatus_i    = $urandom;
      bus.mie_i        = $urandom;
      @(posedge clk); #1;
    end
    rst = 0;
    clear_req();
    repeat (8) begin
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
